im_boot_ctrl: RTL
=================

Name: im_boot_ctrl

Overview:
- Boot-time sequencer for the instruction fetch stage: accepts a stream of 32-bit instruction words and writes them into instruction memory through its write port (WE, W_Ins, word address).
- Holds the CPU core (PC register and fetch path) in reset while loading, then releases it after a fixed drain delay.
- Sits between the host/debug loader interface and the IF stage; owns the CPU reset and the IM write port.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words (power of two, >= 2)
- ADDR_W, 8, word-address width, equals log2(DEPTH)
- RELEASE_DELAY, 4, cycles between last write and CPU reset deassertion (>= 1)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a (re)load
- in_valid  in  1  input word valid
- in_data  in  32  instruction word
- in_last  in  1  marks final word of image, qualified by in_valid
- in_ready  out  1  controller accepts a word this cycle
- WE  out  1  IM write enable, registered
- W_Addr  out  32  IM byte address, {word_addr, 2'b00}, registered
- W_Ins  out  32  IM write data, registered
- cpu_rst  out  1  reset to IF/core, active-high
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in RUN
- err_overflow  out  1  high in ERR
- word_count  out  ADDR_W+1  words written in current load

Behaviour:
- States: IDLE, LOAD, DRAIN, RUN, ERR. Encoding is free; all outputs derive from registers.
- Reset (async):
  - state=IDLE, cpu_rst=1, WE=0, W_Addr=0, W_Ins=0.
  - word_count=0, in_ready=0, busy=0, done=0, err_overflow=0.
- IDLE:
  - cpu_rst=1, in_ready=0.
  - start -> LOAD next cycle; word_count and the address counter clear to 0.
- LOAD:
  - in_ready=1. A word is accepted on in_valid & in_ready.
  - Accepted word: next cycle WE=1, W_Ins=in_data, W_Addr=current word address*4. The address and word_count then increment by 1. Write latency is exactly 1 cycle.
  - No accept: WE=0 next cycle. W_Addr and W_Ins hold their last values.
  - Accepted word with in_last=1 -> DRAIN. Zero-length images are impossible; in_last is only honoured on an accepted word.
  - Accepted word that is word index DEPTH-1 with in_last=0 -> ERR. That word is still written; the address never wraps.
  - start while in LOAD: ignored.
- DRAIN:
  - in_ready=0. Counts RELEASE_DELAY cycles; the first DRAIN cycle carries the final WE pulse.
  - After RELEASE_DELAY cycles -> RUN.
- RUN:
  - cpu_rst=0, done=1, in_ready=0.
  - start -> LOAD. cpu_rst=1 on the next cycle; counters clear.
- ERR:
  - cpu_rst=1, err_overflow=1, in_ready=0, WE=0.
  - start -> LOAD (retry); err_overflow clears with the transition.
- busy=1 exactly in LOAD and DRAIN. cpu_rst=0 only in RUN.
- in_valid with in_ready=0 is not accepted. The source holds data; the controller does not buffer.
- word_count saturates semantics: it never exceeds DEPTH. It holds its value in DRAIN, RUN and ERR until the next start.
- Reset asserted mid-LOAD or mid-DRAIN:
  - Immediate return to IDLE with cpu_rst=1 and WE=0.
  - Partially written IM contents are not cleared.
- start and in_valid in the same IDLE cycle: only start takes effect; in_ready is 0 that cycle.

Test Plan:
- Reset then start, 3 words 0x20080001, 0x20090002, 0x01095020 with last on the third, in_valid held high:
  - WE pulses on 3 consecutive cycles at W_Addr 0x0, 0x4, 0x8.
  - DRAIN lasts 4 cycles, then cpu_rst falls, done=1, word_count=3.
- Gapped stream with in_valid toggling 1,0,1,0,1(last):
  - WE exactly mirrors the accepts delayed by 1 cycle.
  - Addresses increment only on accepts (0x0, 0x4, 0x8).
- Overflow with DEPTH=4, 4 words and no last:
  - 4 writes, last at W_Addr 0xC.
  - Then err_overflow=1, in_ready=0, cpu_rst=1.
  - A fifth in_valid gets no WE.
  - Then start + 1 word with last reaches RUN, err_overflow=0.
- Reload from RUN: start pulse -> cpu_rst=1 on the next cycle, busy=1, word_count=0; a new 2-word image writes from address 0x0.
- Async reset mid-LOAD after 2 words:
  - Assert RST between clock edges; WE and in_ready drop immediately.
  - State is IDLE, cpu_rst=1, and start is required to resume.
- start asserted during LOAD and during DRAIN: no effect on address, count or state timing.

Source files
------------

// File: rtl/im_boot_ctrl_if.sv
// Bundle of the loader handshake, IM write port and status lines of the
// boot sequencer. The master side is the host/debug loader, the slave
// side is the boot controller.
interface im_boot_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              WE;
  logic [31:0]       W_Addr;
  logic [31:0]       W_Ins;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, WE, W_Addr, W_Ins, cpu_rst, busy, done, err_overflow,
           word_count
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, WE, W_Addr, W_Ins, cpu_rst, busy, done, err_overflow,
           word_count
  );
endinterface

// File: rtl/im_boot_ctrl.sv
// Boot-time sequencer: streams instruction words into the IM write port
// while holding the core in reset, then releases the core after a short
// drain delay. Every output comes straight from a register.
module im_boot_ctrl #(
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 4
) (
  input logic           CLK,
  input logic           RST,
  im_boot_ctrl_if.slave bus
);

  localparam int DW = $clog2(RELEASE_DELAY + 1);

  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CntOne    = (ADDR_W + 1)'(1);
  localparam logic [DW-1:0]     DrainOne  = DW'(1);
  localparam logic [DW-1:0]     DrainLast = DW'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [DW-1:0]     r_drainCnt;
  logic              r_inReady;
  logic              r_we;
  logic [31:0]       r_wAddr;
  logic [31:0]       r_wIns;
  logic              r_cpuRst;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_accept;
  logic w_lastIdx;

  // A word is taken only while the controller advertises ready; the final
  // slot of the memory is where an unterminated image overflows.
  always_comb begin
    w_accept  = bus.in_valid & r_inReady;
    w_lastIdx = (r_addr == AddrLast);
  end

  // Sequencer state, write-port registers and status flags in one process
  // so the outputs always move together with the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_drainCnt <= '0;
      r_inReady  <= 1'b0;
      r_we       <= 1'b0;
      r_wAddr    <= '0;
      r_wIns     <= '0;
      r_cpuRst   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (bus.start) begin
            r_state   <= S_LOAD;
            r_addr    <= '0;
            r_count   <= '0;
            r_inReady <= 1'b1;
            r_cpuRst  <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_wIns  <= bus.in_data;
            r_wAddr <= 32'({r_addr, 2'b00});
            r_count <= r_count + CntOne;
            if (!w_lastIdx) begin
              r_addr <= r_addr + AddrOne;
            end
            if (bus.in_last) begin
              r_state    <= S_DRAIN;
              r_inReady  <= 1'b0;
              r_drainCnt <= '0;
            end else if (w_lastIdx) begin
              r_state   <= S_ERR;
              r_inReady <= 1'b0;
              r_busy    <= 1'b0;
              r_err     <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_drainCnt == DrainLast) begin
            r_state  <= S_RUN;
            r_cpuRst <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_drainCnt <= r_drainCnt + DrainOne;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Drive the bundle directly from the registers.
  always_comb begin
    bus.in_ready     = r_inReady;
    bus.WE           = r_we;
    bus.W_Addr       = r_wAddr;
    bus.W_Ins        = r_wIns;
    bus.cpu_rst      = r_cpuRst;
    bus.busy         = r_busy;
    bus.done         = r_done;
    bus.err_overflow = r_err;
    bus.word_count   = r_count;
  end

endmodule
